// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// mem_access_stage_pkg : op codes, FSM encoding and writeback packet type
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

   localparam logic [4:0] OP_JAL = 5'b10000;
   localparam logic [4:0] OP_BEQ = 5'b10001;
   localparam logic [4:0] OP_BLT = 5'b10010;
   localparam logic [4:0] OP_LW  = 5'b10100;
   localparam logic [4:0] OP_SW  = 5'b10101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ERR  = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic        valid;
      logic        wreg;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } wb_pkt_t;

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// mem_access_stage_if : req/ack data-memory port between stage and memory
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  dmem_rdata_i, dmem_ack_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output dmem_rdata_i, dmem_ack_i
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage_timeout_ctr.sv
// ============================================================================
// mem_timeout_ctr : counts un-acked REQ cycles, flags the cycle the limit hits
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr_i,
   input  wire logic inc_i,
   output logic      expired_o
);
   localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Expires on the edge where this increment would reach the limit.
   assign expired_o = inc_i && (cnt_q == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : RV32 word load/store stage with registered writeback.
// Optional MEM_TIMEOUT_EN adds a request timeout and the timeout_o port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          ex_valid_i,
   input  wire logic [4:0]    aluop_i,
   input  wire logic [31:0]   mem_addr_i,
   input  wire logic [31:0]   store_data_i,
   input  wire logic [31:0]   wdata_i,
   input  wire logic [4:0]    wnum_i,
   input  wire logic          wreg_i,
   output logic               stall_o,
   mem_access_stage_if.master dmem,
   output logic               wb_valid_o,
   output logic               wb_wreg_o,
   output logic [4:0]         wb_wnum_o,
   output logic [31:0]        wb_wdata_o,
`ifdef MEM_TIMEOUT_EN
   output logic               timeout_o,
`endif
   output logic               misaligned_o
);
   generate
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   mem_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic        wreg_hold_q, wreg_hold_d;
   logic [4:0]  wnum_hold_q, wnum_hold_d;
   logic        mis_q, mis_d;
   wb_pkt_t     wb_q, wb_d;
   logic        accept;
   logic        expired;

`ifdef MEM_TIMEOUT_EN
   mem_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q != ST_REQ),
      .inc_i     ((state_q == ST_REQ) && !dmem.dmem_ack_i),
      .expired_o (expired)
   );
   assign timeout_o = (state_q == ST_ERR);
`else
   assign expired = 1'b0;
`endif

   assign stall_o = (state_q != ST_IDLE);
   assign accept  = ex_valid_i && !stall_o;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      sdata_d     = sdata_q;
      wreg_hold_d = wreg_hold_q;
      wnum_hold_d = wnum_hold_q;
      mis_d       = 1'b0;
      wb_d        = wb_q;
      wb_d.valid  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!is_mem_op(aluop_i)) begin
                  wb_d = '{valid: 1'b1, wreg: wreg_i, wnum: wnum_i, wdata: wdata_i};
               end else if (mem_addr_i[1:0] != 2'b00) begin
                  mis_d = 1'b1;
                  wb_d  = '{valid: 1'b1, wreg: 1'b0, wnum: wnum_i, wdata: 32'd0};
               end else begin
                  state_d     = ST_REQ;
                  req_d       = 1'b1;
                  we_d        = (aluop_i == OP_SW);
                  addr_d      = {mem_addr_i[31:2], 2'b00};
                  sdata_d     = (aluop_i == OP_SW) ? store_data_i : 32'd0;
                  wreg_hold_d = wreg_i;
                  wnum_hold_d = wnum_i;
               end
            end
         end
         ST_REQ: begin
            // A late ack beats the timeout on the same edge.
            if (dmem.dmem_ack_i) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               wb_d    = '{valid: 1'b1,
                           wreg:  wreg_hold_q && !we_q,
                           wnum:  wnum_hold_q,
                           wdata: we_q ? 32'd0 : dmem.dmem_rdata_i};
            end else if (expired) begin
               state_d = ST_ERR;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wb_d    = '{valid: 1'b1, wreg: 1'b0, wnum: wnum_hold_q, wdata: 32'd0};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         sdata_q     <= 32'd0;
         wreg_hold_q <= 1'b0;
         wnum_hold_q <= 5'd0;
         mis_q       <= 1'b0;
         wb_q        <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         sdata_q     <= sdata_d;
         wreg_hold_q <= wreg_hold_d;
         wnum_hold_q <= wnum_hold_d;
         mis_q       <= mis_d;
         wb_q        <= wb_d;
      end
   end

   assign dmem.dmem_req_o   = req_q;
   assign dmem.dmem_we_o    = we_q;
   assign dmem.dmem_addr_o  = addr_q;
   assign dmem.dmem_wdata_o = sdata_q;
   assign wb_valid_o        = wb_q.valid;
   assign wb_wreg_o         = wb_q.wreg;
   assign wb_wnum_o         = wb_q.wnum;
   assign wb_wdata_o        = wb_q.wdata;
   assign misaligned_o      = mis_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [4:0]  aluop;
   logic [31:0] mem_addr;
   logic [31:0] store_data;
   logic [31:0] wdata;
   logic [4:0]  wnum;
   logic        wreg;
   logic        stall;
   logic        wb_valid;
   logic        wb_wreg;
   logic [4:0]  wb_wnum;
   logic [31:0] wb_wdata;
   logic        misaligned;
`ifdef MEM_TIMEOUT_EN
   logic        timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_stage_if dmem ();

   always #5 clk = ~clk;

   mem_access_stage #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid_i   (ex_valid),
      .aluop_i      (aluop),
      .mem_addr_i   (mem_addr),
      .store_data_i (store_data),
      .wdata_i      (wdata),
      .wnum_i       (wnum),
      .wreg_i       (wreg),
      .stall_o      (stall),
      .dmem         (dmem.master),
      .wb_valid_o   (wb_valid),
      .wb_wreg_o    (wb_wreg),
      .wb_wnum_o    (wb_wnum),
      .wb_wdata_o   (wb_wdata),
`ifdef MEM_TIMEOUT_EN
      .timeout_o    (timeout),
`endif
      .misaligned_o (misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] wd,
                        input logic [4:0] wn, input logic wr);
      ex_valid   = v;
      aluop      = op;
      mem_addr   = a;
      store_data = sd;
      wdata      = wd;
      wnum       = wn;
      wreg       = wr;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      dmem.dmem_ack_i   = 1'b0;
      dmem.dmem_rdata_i = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_req", {31'd0, dmem.dmem_req_o}, 32'd0);
      chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
      chk("rst_wbdata", wb_wdata, 32'd0);
      chk("rst_mis", {31'd0, misaligned}, 32'd0);
      rst = 1'b0;

      // Non-memory op: one-cycle latency writeback
      drive(1'b1, 5'b01101, 32'd0, 32'd0, 32'h7, 5'd5, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("add_wbv", {31'd0, wb_valid}, 32'd1);
      chk("add_wreg", {31'd0, wb_wreg}, 32'd1);
      chk("add_wnum", {27'd0, wb_wnum}, 32'd5);
      chk("add_wdata", wb_wdata, 32'h7);
      chk("add_req", {31'd0, dmem.dmem_req_o}, 32'd0);
      chk("add_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("add_pulse", {31'd0, wb_valid}, 32'd0);
      chk("add_hold", wb_wdata, 32'h7);

      // Ack while idle must be ignored
      dmem.dmem_ack_i = 1'b1;
      @(negedge clk);
      dmem.dmem_ack_i = 1'b0;
      chk("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);
      chk("idle_ack_stall", {31'd0, stall}, 32'd0);

      // LW with ack in the third REQ cycle
      drive(1'b1, 5'b10100, 32'h104, 32'h0, 32'h55, 5'd9, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("lw_addr", dmem.dmem_addr_o, 32'h104);
      chk("lw_we", {31'd0, dmem.dmem_we_o}, 32'd0);
      for (int c = 1; c <= 3; c++) begin
         chk("lw_stall", {31'd0, stall}, 32'd1);
         chk("lw_req", {31'd0, dmem.dmem_req_o}, 32'd1);
         chk("lw_wbv_low", {31'd0, wb_valid}, 32'd0);
         if (c == 3) begin
            dmem.dmem_ack_i   = 1'b1;
            dmem.dmem_rdata_i = 32'hDEAD_BEEF;
         end
         @(negedge clk);
      end
      dmem.dmem_ack_i   = 1'b0;
      dmem.dmem_rdata_i = 32'd0;
      chk("lw_wbv", {31'd0, wb_valid}, 32'd1);
      chk("lw_wdata", wb_wdata, 32'hDEAD_BEEF);
      chk("lw_wreg", {31'd0, wb_wreg}, 32'd1);
      chk("lw_wnum", {27'd0, wb_wnum}, 32'd9);
      chk("lw_done_stall", {31'd0, stall}, 32'd0);
      chk("lw_done_req", {31'd0, dmem.dmem_req_o}, 32'd0);

      // SW with immediate ack, then back-to-back ADD while wb_valid is high
      drive(1'b1, 5'b10101, 32'h200, 32'h1234_5678, 32'h0, 5'd4, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("sw_req", {31'd0, dmem.dmem_req_o}, 32'd1);
      chk("sw_we", {31'd0, dmem.dmem_we_o}, 32'd1);
      chk("sw_wdata", dmem.dmem_wdata_o, 32'h1234_5678);
      chk("sw_addr", dmem.dmem_addr_o, 32'h200);
      chk("sw_wbv_early", {31'd0, wb_valid}, 32'd0);
      dmem.dmem_ack_i = 1'b1;
      @(negedge clk);
      dmem.dmem_ack_i = 1'b0;
      chk("sw_wbv", {31'd0, wb_valid}, 32'd1);
      chk("sw_wreg", {31'd0, wb_wreg}, 32'd0);
      chk("sw_wb_wdata", wb_wdata, 32'd0);
      chk("sw_stall", {31'd0, stall}, 32'd0);
      drive(1'b1, 5'b00001, 32'd0, 32'd0, 32'hAB, 5'd0, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("b2b_wbv", {31'd0, wb_valid}, 32'd1);
      chk("b2b_wdata", wb_wdata, 32'hAB);
      chk("b2b_wnum0", {27'd0, wb_wnum}, 32'd0);

      // Misaligned LW
      drive(1'b1, 5'b10100, 32'h102, 32'd0, 32'd0, 5'd6, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("mis_pulse", {31'd0, misaligned}, 32'd1);
      chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
      chk("mis_wreg", {31'd0, wb_wreg}, 32'd0);
      chk("mis_req", {31'd0, dmem.dmem_req_o}, 32'd0);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("mis_clear", {31'd0, misaligned}, 32'd0);
      chk("mis_req2", {31'd0, dmem.dmem_req_o}, 32'd0);

      // Reset in the middle of a request; a later ack is ignored
      drive(1'b1, 5'b10100, 32'h300, 32'd0, 32'd0, 5'd2, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      chk("mrst_req_pre", {31'd0, dmem.dmem_req_o}, 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_req", {31'd0, dmem.dmem_req_o}, 32'd0);
      chk("mrst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;
      dmem.dmem_ack_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mrst_ack_wbv", {31'd0, wb_valid}, 32'd0);
         chk("mrst_ack_req", {31'd0, dmem.dmem_req_o}, 32'd0);
      end
      dmem.dmem_ack_i = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // No ack: four REQ cycles, one ERR cycle, then error writeback
      drive(1'b1, 5'b10100, 32'h40, 32'd0, 32'd0, 5'd7, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         chk("to_req", {31'd0, dmem.dmem_req_o}, 32'd1);
         chk("to_no_pulse", {31'd0, timeout}, 32'd0);
         @(negedge clk);
      end
      chk("to_pulse", {31'd0, timeout}, 32'd1);
      chk("to_req_drop", {31'd0, dmem.dmem_req_o}, 32'd0);
      chk("to_err_stall", {31'd0, stall}, 32'd1);
      chk("to_err_wbv", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      chk("to_wbv", {31'd0, wb_valid}, 32'd1);
      chk("to_wreg", {31'd0, wb_wreg}, 32'd0);
      chk("to_stall", {31'd0, stall}, 32'd0);
      chk("to_pulse_end", {31'd0, timeout}, 32'd0);

      // Ack on the fourth REQ cycle wins over the timeout
      drive(1'b1, 5'b10100, 32'h44, 32'd0, 32'd0, 5'd8, 1'b1);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         chk("toack_req", {31'd0, dmem.dmem_req_o}, 32'd1);
         if (c == 4) begin
            dmem.dmem_ack_i   = 1'b1;
            dmem.dmem_rdata_i = 32'hCAFE_0001;
         end
         @(negedge clk);
      end
      dmem.dmem_ack_i = 1'b0;
      chk("toack_wbv", {31'd0, wb_valid}, 32'd1);
      chk("toack_wdata", wb_wdata, 32'hCAFE_0001);
      chk("toack_wreg", {31'd0, wb_wreg}, 32'd1);
      chk("toack_no_to", {31'd0, timeout}, 32'd0);
      chk("toack_stall", {31'd0, stall}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the sequential RV32 core.
- Consumes the execute outputs: ALU op, computed memory address, store data, ALU/link result, destination register number and write enable.
- Performs word loads and stores over a variable-latency req/ack data-memory port, stalling upstream while a transaction is outstanding.
- Presents a registered, single-cycle writeback packet to the register file.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles `dmem_req_o` may stay high without ack. Used only with the optional feature.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset rst, synchronous, active-high.
- ex_valid_i, input, 1: execute packet valid this cycle.
- aluop_i, input, 5: op code from execute (LW=10100, SW=10101, others non-memory).
- mem_addr_i, input, 32: effective byte address.
- store_data_i, input, 32: SW data.
- wdata_i, input, 32: ALU/link result for non-memory ops.
- wnum_i, input, 5: destination register number.
- wreg_i, input, 1: destination write enable.
- stall_o, output, 1: upstream must hold its packet.
- dmem_req_o, output, 1: memory request.
- dmem_we_o, output, 1: 1 = store.
- dmem_addr_o, output, 32: word-aligned address.
- dmem_wdata_o, output, 32: store data.
- dmem_rdata_i, input, 32: load data, valid with ack.
- dmem_ack_i, input, 1: transaction complete.
- wb_valid_o, output, 1: one-cycle writeback strobe.
- wb_wreg_o, output, 1: register write enable.
- wb_wnum_o, output, 5: destination register number.
- wb_wdata_o, output, 32: writeback data.
- misaligned_o, output, 1: one-cycle pulse on misaligned LW/SW.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset has priority over every other event. Mid-transaction reset drops `dmem_req_o` at the next edge and returns to IDLE. An ack arriving afterwards is ignored.
- States: IDLE, REQ, and ERR (ERR only with the optional feature).
- `stall_o` = (state != IDLE), combinational.
- A packet is accepted when ex_valid_i && !stall_o. All inputs are captured at the accept edge.
- IDLE, non-memory op accepted:
  - Next cycle: wb_valid_o=1, wb_wreg_o=wreg_i, wb_wnum_o=wnum_i, wb_wdata_o=wdata_i.
  - Latency 1; state stays IDLE.
- IDLE, LW/SW accepted with mem_addr_i[1:0] != 0:
  - No request issued.
  - Next cycle: misaligned_o=1, wb_valid_o=1, wb_wreg_o=0.
  - State stays IDLE.
- IDLE, aligned LW/SW accepted:
  - Next state REQ.
  - dmem_req_o=1, dmem_we_o=(op==SW), dmem_addr_o={addr[31:2],2'b00}, dmem_wdata_o=store_data_i (SW) or 0 (LW).
  - These outputs are held stable until ack.
- REQ:
  - Ack sampled at each edge.
  - On dmem_ack_i=1: dmem_req_o drops, state returns to IDLE, and next cycle wb_valid_o=1.
    - LW: wb_wreg_o=wreg_i, wb_wdata_o=dmem_rdata_i.
    - SW: wb_wreg_o=0, wb_wdata_o=0.
  - Minimum mem-op latency (ack in first REQ cycle): wb_valid_o 2 cycles after accept.
- Ack while not in REQ is ignored.
- wb_valid_o and misaligned_o are single-cycle pulses. Other wb_* fields hold their last value.
- A register number of 0 is passed through unchanged; the register file discards writes to x0.
- Back-to-back: a new packet may be accepted in the same cycle wb_valid_o is high, because state is already IDLE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entering REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, dmem_req_o drops and state goes to ERR for one cycle. In ERR, stall_o=1 and timeout_o pulses (extra port, output, 1).
  - The next cycle, wb_valid_o=1 with wb_wreg_o=0; state returns to IDLE.
  - Ack arriving on the same edge the count reaches TIMEOUT_CYCLES wins: normal completion, no timeout.
- MEM_TIMEOUT_EN undefined: no counter and no timeout_o port. REQ waits indefinitely.

Decomposition:
- Shared package holds:
  - ALU op constants: OP_LW=5'b10100, OP_SW=5'b10101, OP_JAL=5'b10000, OP_BEQ=5'b10001, OP_BLT=5'b10010.
  - Memory-stage state encoding.
  - A wb-packet typedef {valid, wreg, wnum[4:0], wdata[31:0]}.
- One natural sub-module: mem_timeout_ctr (counter plus compare), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Reset: rst=1 for 2 cycles mid-REQ, then ack=1 → req stays 0, stall_o=0, wb_valid_o never pulses.
2. ADD op=01101, wdata=0x0000_0007, wnum=5, wreg=1 → one cycle later wb_valid_o=1, wb_wnum_o=5, wb_wdata_o=7; dmem_req_o stays 0.
3. LW addr=0x0000_0104, ack after 3 REQ cycles with rdata=0xDEAD_BEEF, wnum=9:
   - stall_o=1 for 3 cycles.
   - dmem_addr_o=0x104, dmem_we_o=0.
   - Then wb_wdata_o=0xDEADBEEF, wb_wreg_o=1, wb_wnum_o=9.
4. SW addr=0x0000_0200, data=0x1234_5678, immediate ack:
   - dmem_we_o=1, dmem_wdata_o=0x12345678.
   - wb_valid_o 2 cycles after accept with wb_wreg_o=0.
5. LW addr=0x0000_0102 → misaligned_o=1 and wb_valid_o=1 with wb_wreg_o=0 the next cycle; no dmem_req_o.
6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
   - req high 4 cycles, then timeout_o pulse.
   - Then wb_valid_o=1 with wb_wreg_o=0; stall_o releases.
   - Repeat with ack on the 4th cycle → normal completion, no timeout.
